// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side hazard unit for the five-stage RV32 pipe.
// A three-entry scoreboard (EX, MEM, WB) of in-flight destinations drives
// load-use stalls, redirect flushes, freeze, EX forwarding selects,
// decode write-back bypass and stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             freeze,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             id_byp_rs1,
  output logic             id_byp_rs2,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } sb_entry_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  sb_entry_t        ex_q, mem_q, wb_q;
  sb_entry_t        ex_d, mem_d, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic load_use, issue;

  // x0 is never a real producer, and unused sources never create a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] s,
                                    input logic use_s);
    return use_s & e.v & e.we & (e.rd != 5'd0) & (e.rd == s);
  endfunction

  // Younger EX producer wins over the MEM producer; a matching EX load never
  // reaches here because it holds the consumer back as a load-use stall.
  function automatic logic [1:0] pick_fwd(input logic ex_m, input logic ex_ld,
                                          input logic mem_m);
    if (ex_m && !ex_ld) return SEL_MEM;
    if (mem_m)          return SEL_WB;
    return SEL_REG;
  endfunction

  // Hazard detection and pipeline-control outputs (freeze overrides all).
  always_comb begin
    ex_m1      = sb_match(ex_q,  id_rs1, id_use_rs1);
    ex_m2      = sb_match(ex_q,  id_rs2, id_use_rs2);
    mem_m1     = sb_match(mem_q, id_rs1, id_use_rs1);
    mem_m2     = sb_match(mem_q, id_rs2, id_use_rs2);
    load_use   = id_valid & ex_q.ld & (ex_m1 | ex_m2);
    issue      = id_valid & ~load_use & ~ex_redirect;
    freeze     = mem_stall;
    flush_if   = ~mem_stall & ex_redirect;
    bubble_ex  = ~mem_stall & (ex_redirect | load_use);
    stall_if   = ~mem_stall & ~ex_redirect & load_use;
    id_byp_rs1 = sb_match(wb_q, id_rs1, id_use_rs1);
    id_byp_rs2 = sb_match(wb_q, id_rs2, id_use_rs2);
  end

  // Next-state: scoreboard shift, select load and counters, all held on freeze.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_stall) begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = issue ? '{v: 1'b1, rd: id_rd, we: id_rd_we, ld: id_is_load} : '0;
      fwd_a_d = issue ? pick_fwd(ex_m1, ex_q.ld, mem_m1) : SEL_REG;
      fwd_b_d = issue ? pick_fwd(ex_m2, ex_q.ld, mem_m2) : SEL_REG;
      if (load_use && !ex_redirect) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (ex_redirect)              flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= SEL_REG;
      fwd_b_q     <= SEL_REG;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus a randomized run against an
// age-based reference model of the in-flight instruction window.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_rd_we = 0, id_is_load = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic ex_redirect = 0, mem_stall = 0;
  logic freeze, stall_if, bubble_ex, flush_if, id_byp_rs1, id_byp_rs2;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_stall(mem_stall), .freeze(freeze), .stall_if(stall_if),
    .bubble_ex(bubble_ex), .flush_if(flush_if), .id_byp_rs1(id_byp_rs1),
    .id_byp_rs2(id_byp_rs2), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- reference model ----------------
  // hist[0] is the youngest in-flight instruction (age 0 = in EX).
  typedef struct packed { logic wr; logic [4:0] rd; logic ld; } inst_t;
  inst_t hist[$];
  logic [1:0] m_fwd_a, m_fwd_b;
  int m_stalls, m_flushes;

  function automatic int writer_age(input logic [4:0] s, input logic use_s);
    if (!use_s || s == 0) return -1;
    for (int k = 0; k < 3; k++)
      if (hist[k].wr && hist[k].rd == s) return k;
    return -1;
  endfunction

  function automatic logic m_load_use();
    int a1, a2;
    a1 = writer_age(id_rs1, id_use_rs1);
    a2 = writer_age(id_rs2, id_use_rs2);
    return id_valid && hist[0].ld && (a1 == 0 || a2 == 0);
  endfunction

  function automatic logic m_byp(input logic [4:0] s, input logic use_s);
    return use_s && s != 0 && hist[2].wr && hist[2].rd == s;
  endfunction

  function automatic logic [1:0] age_to_sel(input int age);
    if (age == 0) return 2'b01;
    if (age == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back('0);
    m_fwd_a = 0; m_fwd_b = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    logic lu, iss;
    inst_t n;
    if (mem_stall) return;
    lu  = m_load_use();
    iss = id_valid && !lu && !ex_redirect;
    m_fwd_a = iss ? age_to_sel(writer_age(id_rs1, id_use_rs1)) : 2'b00;
    m_fwd_b = iss ? age_to_sel(writer_age(id_rs2, id_use_rs2)) : 2'b00;
    if (lu && !ex_redirect) m_stalls++;
    if (ex_redirect) m_flushes++;
    n = iss ? '{wr: id_rd_we, rd: id_rd, ld: id_is_load} : '0;
    hist.push_front(n);
    void'(hist.pop_back());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld;
  endtask

  task automatic reset_dut();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0; mem_stall = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    checks++; if ({freeze, stall_if, bubble_ex, flush_if, id_byp_rs1, id_byp_rs2} !== 6'b0)
      $display("FAIL reset_ctrl got=%b want=000000", {freeze, stall_if, bubble_ex, flush_if, id_byp_rs1, id_byp_rs2});
    else passed++;
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0)
      $display("FAIL reset_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel}); else passed++;
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0)
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); else passed++;
  endtask

  task automatic test_alu_chain();
    reset_dut();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();           // add x5
    set_id(1, 5, 3, 1, 1, 6, 1, 0); #1;               // sub x6,x5,x3
    checks++; if (stall_if !== 0 || bubble_ex !== 0)
      $display("FAIL alu_nostall got=%b%b want=00", stall_if, bubble_ex); else passed++;
    tick();
    checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00)
      $display("FAIL alu_fwd_ex got=%b/%b want=01/00", fwd_a_sel, fwd_b_sel); else passed++;
    reset_dut();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();           // add x5
    set_id(1, 1, 2, 1, 1, 10, 1, 0); tick();          // unrelated
    set_id(1, 5, 3, 1, 1, 6, 1, 0); tick();           // sub reads x5
    checks++; if (fwd_a_sel !== 2'b10)
      $display("FAIL alu_fwd_mem got=%b want=10", fwd_a_sel); else passed++;
  endtask

  task automatic test_load_use();
    reset_dut();
    set_id(1, 1, 0, 1, 0, 7, 1, 1); tick();           // lw x7
    set_id(1, 7, 7, 1, 1, 8, 1, 0); #1;               // add x8,x7,x7
    checks++; if (stall_if !== 1 || bubble_ex !== 1 || flush_if !== 0)
      $display("FAIL lu_stall got=%b%b%b want=110", stall_if, bubble_ex, flush_if); else passed++;
    tick();
    checks++; if (stall_if !== 0 || bubble_ex !== 0 || stall_cnt !== 4'd1)
      $display("FAIL lu_one_cycle got=%b%b cnt=%0d want=00 cnt=1", stall_if, bubble_ex, stall_cnt);
    else passed++;
    tick();
    checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10 || stall_cnt !== 4'd1)
      $display("FAIL lu_fwd got=%b/%b cnt=%0d want=10/10 cnt=1", fwd_a_sel, fwd_b_sel, stall_cnt);
    else passed++;
  endtask

  task automatic test_x0_unused();
    reset_dut();
    set_id(1, 1, 0, 1, 0, 0, 1, 1); tick();           // lw x0
    set_id(1, 0, 0, 1, 1, 4, 1, 0); #1;
    checks++; if (stall_if !== 0)
      $display("FAIL x0_stall got=%b want=0", stall_if); else passed++;
    tick();
    checks++; if (fwd_a_sel !== 0 || fwd_b_sel !== 0)
      $display("FAIL x0_fwd got=%b/%b want=00/00", fwd_a_sel, fwd_b_sel); else passed++;
    reset_dut();
    set_id(1, 1, 0, 1, 0, 9, 1, 1); tick();           // lw x9
    set_id(1, 1, 9, 1, 0, 4, 1, 0); #1;               // I-type, rs2 field = 9 unused
    checks++; if (stall_if !== 0 || bubble_ex !== 0)
      $display("FAIL unused_stall got=%b%b want=00", stall_if, bubble_ex); else passed++;
    tick();
    checks++; if (fwd_a_sel !== 0 || fwd_b_sel !== 0)
      $display("FAIL unused_fwd got=%b/%b want=00/00", fwd_a_sel, fwd_b_sel); else passed++;
  endtask

  task automatic test_redirect_loaduse();
    reset_dut();
    set_id(1, 1, 0, 1, 0, 7, 1, 1); tick();
    set_id(1, 7, 7, 1, 1, 8, 1, 0); ex_redirect = 1; #1;
    checks++; if (flush_if !== 1 || bubble_ex !== 1 || stall_if !== 0)
      $display("FAIL redir_ctrl got=%b%b%b want=110", flush_if, bubble_ex, stall_if); else passed++;
    tick();
    ex_redirect = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0)
      $display("FAIL redir_cnt got=%0d/%0d want=1/0", flush_cnt, stall_cnt); else passed++;
  endtask

  task automatic test_freeze();
    reset_dut();
    set_id(1, 1, 0, 1, 0, 7, 1, 1); tick();           // lw x7
    set_id(1, 7, 2, 1, 1, 8, 1, 0); mem_stall = 1; ex_redirect = 1; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (freeze !== 1 || stall_if !== 0 || bubble_ex !== 0 || flush_if !== 0)
        $display("FAIL frz_ctrl c=%0d got=%b%b%b%b want=1000", c, freeze, stall_if, bubble_ex, flush_if);
      else passed++;
      tick();
      checks++; if (stall_cnt !== 0 || flush_cnt !== 0 || fwd_a_sel !== 2'b00)
        $display("FAIL frz_hold c=%0d got=%0d/%0d/%b want=0/0/00", c, stall_cnt, flush_cnt, fwd_a_sel);
      else passed++;
    end
    mem_stall = 0; ex_redirect = 0; #1;
    checks++; if (stall_if !== 1 || bubble_ex !== 1)
      $display("FAIL frz_resolve got=%b%b want=11", stall_if, bubble_ex); else passed++;
    tick();
    checks++; if (stall_cnt !== 4'd1 || stall_if !== 0)
      $display("FAIL frz_after got=cnt%0d stall%b want=cnt1 stall0", stall_cnt, stall_if); else passed++;
    reset_dut();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();           // add x5
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();   // x5 now in WB
    set_id(1, 5, 3, 1, 1, 6, 1, 0); mem_stall = 1; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (id_byp_rs1 !== 1 || id_byp_rs2 !== 0)
        $display("FAIL frz_byp c=%0d got=%b%b want=10", c, id_byp_rs1, id_byp_rs2); else passed++;
      tick();
    end
    mem_stall = 0;
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 1; tick(); ex_redirect = 0;
    set_id(1, 1, 0, 1, 0, 7, 1, 1); tick();
    set_id(1, 7, 7, 1, 1, 8, 1, 0); #1;
    checks++; if (stall_if !== 1 || flush_cnt !== 4'd1)
      $display("FAIL rstmid_pre got=%b cnt=%0d want=1 cnt=1", stall_if, flush_cnt); else passed++;
    #2 rst = 1; #1;
    checks++; if ({stall_if, bubble_ex, flush_if, freeze, fwd_a_sel, fwd_b_sel} !== 8'b0 ||
                  stall_cnt !== 0 || flush_cnt !== 0)
      $display("FAIL rstmid_async got=%b%b%b%b %b%b cnt=%0d/%0d want=all0", stall_if, bubble_ex,
               flush_if, freeze, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt);
    else passed++;
    @(posedge clk); #1; rst = 0; model_reset(); #1;
    checks++; if (stall_if !== 0 || bubble_ex !== 0)
      $display("FAIL rstmid_post got=%b%b want=00", stall_if, bubble_ex); else passed++;
  endtask

  task automatic test_counter_wrap();
    reset_dut();
    ex_redirect = 1;
    for (int c = 0; c < 15; c++) tick();
    checks++; if (flush_cnt !== 4'd15)
      $display("FAIL wrap_15 got=%0d want=15", flush_cnt); else passed++;
    tick();
    checks++; if (flush_cnt !== 4'd0)
      $display("FAIL wrap_16 got=%0d want=0", flush_cnt); else passed++;
    ex_redirect = 0;
  endtask

  task automatic test_random();
    int errs = 0;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      set_id(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_stall   = ($urandom_range(0, 4) == 0);
      #1;
      checks++;
      if (freeze !== mem_stall ||
          stall_if  !== (!mem_stall && !ex_redirect && m_load_use()) ||
          bubble_ex !== (!mem_stall && (ex_redirect || m_load_use())) ||
          flush_if  !== (!mem_stall && ex_redirect) ||
          id_byp_rs1 !== m_byp(id_rs1, id_use_rs1) ||
          id_byp_rs2 !== m_byp(id_rs2, id_use_rs2) ||
          fwd_a_sel !== m_fwd_a || fwd_b_sel !== m_fwd_b ||
          stall_cnt !== CNT_W'(m_stalls) || flush_cnt !== CNT_W'(m_flushes)) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand c=%0d got=f%b s%b b%b fl%b y%b%b a%b b%b sc%0d fc%0d want=f%b s%b b%b fl%b y%b%b a%b b%b sc%0d fc%0d",
                   c, freeze, stall_if, bubble_ex, flush_if, id_byp_rs1, id_byp_rs2, fwd_a_sel,
                   fwd_b_sel, stall_cnt, flush_cnt, mem_stall,
                   (!mem_stall && !ex_redirect && m_load_use()),
                   (!mem_stall && (ex_redirect || m_load_use())), (!mem_stall && ex_redirect),
                   m_byp(id_rs1, id_use_rs1), m_byp(id_rs2, id_use_rs2), m_fwd_a, m_fwd_b,
                   CNT_W'(m_stalls), CNT_W'(m_flushes));
      end else passed++;
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_unused();
    test_redirect_loaduse();
    test_freeze();
    test_reset_mid_stall();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core (IF, ID, EX, MEM, WB). It sits beside the decode stage and keeps a three-entry scoreboard of in-flight destination registers. From that scoreboard it sequences the IF/ID and ID/EX pipeline registers: load-use stalls, branch/jump flushes and whole-pipe freezes. It also produces EX-stage forwarding selects, decode-stage write-back bypass flags, and stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs1, id_rs2  in  5 each  source register addresses, from instr[19:15] and instr[24:20].
- id_use_rs1, id_use_rs2  in  1 each  the instruction actually reads that source.
- id_rd  in  5  destination address, instr[11:7].
- id_rd_we  in  1  the instruction writes rd.
- id_is_load  in  1  the instruction is a load (result comes from memory).
- ex_redirect  in  1  a taken branch or jump has resolved in EX this cycle.
- mem_stall  in  1  the memory stage needs another cycle.
- freeze  out  1  all pipeline registers and the PC hold; equals mem_stall.
- stall_if  out  1  PC and IF/ID hold.
- bubble_ex  out  1  clear the control fields of ID/EX (insert a NOP).
- flush_if  out  1  clear IF/ID (wrong-path instruction).
- id_byp_rs1, id_byp_rs2  out  1 each  substitute reg_write_data for the register-file output in ID.
- fwd_a_sel, fwd_b_sel  out  2 each  registered operand select for EX: 00 = register value, 01 = MEM-stage ALU result, 10 = WB result.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- **Scoreboard.** Three entries: EX, MEM and WB. Each entry holds {v, rd, we, ld}.
  - An entry "matches" source s when: v=1, we=1, rd≠0 and rd==s, and the matching id_use_* bit is 1.
  - Register x0 never matches.
- **Load-use hazard.** `load_use` = id_valid & (EX entry has ld=1 and matches id_rs1 or id_rs2).
- **Issue.** `issue` = id_valid & !load_use & !ex_redirect.
- **Freeze** (mem_stall=1) overrides everything else:
  - freeze=1; stall_if=0, bubble_ex=0, flush_if=0.
  - The scoreboard, fwd_*_sel and both counters hold.
- **Redirect** (ex_redirect=1, no freeze), which has priority over load_use:
  - flush_if=1, bubble_ex=1, stall_if=0.
  - The wrong-path instruction in ID is dropped.
- **Load-use** (no freeze, no redirect): stall_if=1, bubble_ex=1.
- **Scoreboard shift** on every non-frozen edge:
  - WB ← MEM, MEM ← EX.
  - EX ← {1, id_rd, id_rd_we, id_is_load} if issue; otherwise EX ← all zero.
- **Forwarding selects.** fwd_a_sel (for rs1) and fwd_b_sel (for rs2) load on every non-frozen edge.
  - If issue is 0, the select loads 00.
  - Otherwise 01 if the current EX entry matches and has ld=0.
  - Otherwise 10 if the current MEM entry matches.
  - Otherwise 00.
  - The EX-entry (younger) match has priority over the MEM-entry match.
- **WB bypass.** id_byp_rsN = current WB entry matches id_rsN. It is combinational and is also valid during freeze.
- **Counters.** Both counters wrap modulo 2^CNT_W.
  - stall_cnt += 1 on each edge where load_use & !ex_redirect & !mem_stall.
  - flush_cnt += 1 on each edge where ex_redirect & !mem_stall.
- **Redirect during freeze.** When ex_redirect and mem_stall are high together, the redirect is not acted on. EX is frozen and re-asserts ex_redirect on the next unfrozen cycle.

## Timing
- **Reset values:** all scoreboard entries zero; fwd_a_sel = fwd_b_sel = 00; stall_cnt = flush_cnt = 0. With inputs low, all outputs are 0.
- **Combinational outputs:** freeze, stall_if, bubble_ex, flush_if and id_byp_* respond in the same cycle as their inputs.
- **Forwarding selects:** fwd_*_sel become valid the cycle after issue, aligned with ID/EX contents.
- **Load-use stall length:** exactly 1 cycle. On the next cycle the load sits in MEM and the consumer issues with fwd=10.
- **Back-to-back loads:** each load-use pair costs one bubble.
- **Flush cost:** a redirect costs 1 bubble in EX plus the flushed IF/ID slot.
- **Reset mid-stall or mid-freeze:** returns the block to the reset state immediately. No bubble or pending redirect survives reset.

## Test plan
- **ALU chain forwarding.** Issue `add x5` then immediately `sub` reading x5 as rs1 → no stall; the sub sees fwd_a_sel=01 in EX. With one unrelated instruction between them → fwd_a_sel=10.
- **Load-use.** Issue `lw x7` then `add x8,x7,x7` → stall_if=1 and bubble_ex=1 for exactly 1 cycle; stall_cnt goes 0→1; the add then gets fwd_a_sel=fwd_b_sel=10.
- **x0 and unused sources.** A load to x0 followed by a reader of x0, and a load to x9 followed by an I-type instruction whose instr[24:20]=9 with id_use_rs2=0 → no stall, selects 00.
- **Redirect with pending load-use.** ex_redirect=1 in the same cycle as a load_use condition → flush_if=1, bubble_ex=1, stall_if=0; flush_cnt=1, stall_cnt unchanged.
- **Freeze.** Hold mem_stall=1 for 3 cycles while a hazard is pending → the scoreboard, selects and counters are unchanged; the stall resolves on the first unfrozen cycle. WB match during freeze → id_byp_rs1=1 throughout.
- **Reset and counter wrap.** Assert rst mid load-use stall → all outputs return to 0 asynchronously. With CNT_W=4, sixteen redirects → flush_cnt wraps to 0.
